spwm_capture: RTL and testbench
===============================

SPWM_CAPTURE -- requirements
Module: spwm_capture

Interface
REQ-001 SHALL provide parameter SYNC_STAGES, default 2, meaning the number of input synchronizer flops per gate input (allowed 2..3).
REQ-002 SHALL have one clock and a synchronous, active-low reset: clk_pwm is the sole clock, and rst_n is sampled only on the rising edge of clk_pwm.
REQ-003 SHALL provide port clk_pwm, input, 1 bit: the 50 MHz PWM-domain clock, which also clocks the MMIO bus.
REQ-004 SHALL provide port rst_n, input, 1 bit: synchronous active-low reset.
REQ-005 SHALL provide port bus_wr, input, 1 bit: MMIO write strobe, one cycle per access.
REQ-006 SHALL provide port bus_rd, input, 1 bit: MMIO read strobe, one cycle per access.
REQ-007 SHALL provide port bus_addr, input, 6 bits: register address.
REQ-008 SHALL provide port bus_wdata, input, 8 bits: write data.
REQ-009 SHALL provide port bus_rdata, output, 8 bits: combinational read data for bus_addr.
REQ-010 SHALL provide port out_en, output, 1 bit: registered, high for exactly the one cycle following each bus_rd.
REQ-011 SHALL provide ports AH, AL, BH, BL, CH, CL, input, 1 bit each: monitored three-phase gate signals.
REQ-012 SHALL provide port fault, output, 1 bit: OR of the three sticky shoot-through flags.

Function
REQ-013 SHALL pass each gate input through SYNC_STAGES flops; all logic below uses only the synchronized values (xHs, xLs).
REQ-014 SHALL implement the following register map:
- 0x00 CTRL: bit0 = enable (R/W), other bits read 0.
- 0x01 STATUS: bits2:0 = shoot-through fault A/B/C; bits5:3 = new-measurement flags A/B/C. Both fields are W1C.
- 0x02/0x03 A_HIGH lo/hi; 0x04/0x05 A_PER lo/hi.
- 0x06..0x09 same layout for phase B; 0x0A..0x0D same layout for phase C.
- All other addresses read 0x00 and ignore writes.
REQ-015 Each phase SHALL contain a 16-bit period_cnt and a 16-bit high_cnt that hold at 0 while enable=0.
REQ-016 While enable=1, period_cnt SHALL increment every cycle, and high_cnt SHALL increment every cycle in which xHs=1. Both counters saturate at 0xFFFF.
REQ-017 A rising edge of xHs is defined as xHs=1 with the previous-cycle value 0. On that cycle, both counters SHALL load 1.
REQ-018 On a rising edge of xHs with the per-phase armed bit =1, the PER register SHALL capture the pre-load period_cnt, the HIGH register SHALL capture the pre-load high_cnt, and the new flag SHALL be set.
REQ-019 The first rising edge after enable goes 0->1 SHALL only set armed and SHALL capture nothing.
REQ-020 enable=0 SHALL clear armed and SHALL leave the PER/HIGH registers and the STATUS register unchanged.
REQ-021 A captured value of 0xFFFF SHALL denote saturation (timeout or stuck level); no separate flag exists.
REQ-022 A read of a lo-byte address SHALL return the live lo byte and, on that cycle, copy the corresponding hi byte into a single shared 8-bit shadow.
REQ-023 A read of any hi-byte address SHALL return the shadow, so that a 16-bit read is atomic when the lo byte is read first.
REQ-024 A capture occurring between the lo-byte and hi-byte reads SHALL NOT alter the shadow.
REQ-025 Shoot-through detection SHALL run independently of enable: if xHs=1 and xLs=1 in the same cycle, the phase fault flag SHALL set on the next edge.
REQ-026 When a set condition and a W1C clear hit the same STATUS bit in the same cycle, the set SHALL win.
REQ-027 fault SHALL be registered, equal the OR of STATUS bits2:0, and update in the same cycle as those bits.
REQ-028 Simultaneous events on different phases SHALL be handled independently, with no priority between phases.

Reset
REQ-029 While rst_n=0 at a clock edge, all of the following SHALL clear to 0: synchronizer flops, counters, armed bits, PER/HIGH registers, shadow, CTRL, STATUS, out_en and fault.
REQ-030 A reset asserted mid-measurement SHALL discard the partial count, and the first rising edge after reset plus enable SHALL only arm.

Verification
REQ-031 Scenario: enable=1; AH square wave with period 100 cycles and 30 high; AL = ~AH with no overlap -> after the 2nd rising edge, A_PER=100 (0x0064), A_HIGH=30 (0x001E), STATUS bit3=1, fault=0.
REQ-032 Scenario: AH and AL both 1 for a single cycle -> STATUS bit0=1 and fault=1 exactly SYNC_STAGES+1 cycles after the overlap; write 0x01 to STATUS -> bit0=0 and fault=0.
REQ-033 Scenario: AH held low for 70000 cycles after arming, then a rising edge -> A_PER=0xFFFF.
REQ-034 Scenario: read 0x04 (A_PER lo); force a new capture; then read 0x05 (A_PER hi) -> the hi byte belongs to the old value, and out_en pulses one cycle after each bus_rd.
REQ-035 Scenario: a STATUS W1C write to bit3 lands on the same cycle as a new phase-A capture -> bit3 remains 1.
REQ-036 Scenario: rst_n=0 for one cycle mid-period with enable previously 1 -> all registers read 0x00, and the next two rising edges yield only the first capture after re-enable.

Source files
------------

// File: rtl/spwm_capture.sv
// Three-phase PWM gate monitor: per-phase period / high-time capture and
// sticky shoot-through detection behind a byte-wide MMIO register map.
module spwm_capture #(
  parameter int SYNC_STAGES = 2  // input synchronizer depth, 2..3
) (
  input  logic       clk_pwm,
  input  logic       rst_n,
  input  logic       bus_wr,
  input  logic       bus_rd,
  input  logic [5:0] bus_addr,
  input  logic [7:0] bus_wdata,
  output logic [7:0] bus_rdata,
  output logic       out_en,
  input  logic       AH,
  input  logic       AL,
  input  logic       BH,
  input  logic       BL,
  input  logic       CH,
  input  logic       CL,
  output logic       fault
);

  localparam logic [15:0] CNT_MAX     = 16'hFFFF;
  localparam logic [5:0]  ADDR_CTRL   = 6'h00;
  localparam logic [5:0]  ADDR_STATUS = 6'h01;
  localparam logic [5:0]  ADDR_FIRST  = 6'h02;
  localparam logic [5:0]  ADDR_LAST   = 6'h0D;

  logic [2:0]                  h_raw, l_raw;
  logic [2:0][SYNC_STAGES-1:0] h_sync, l_sync;
  logic [2:0]                  hs, ls, hs_prev, rise, armed, capture;
  logic [2:0][15:0]            period_cnt, high_cnt, per_reg, high_reg;
  logic                        enable;
  logic [5:0]                  status, status_clr, status_nxt;
  logic [7:0]                  shadow;
  logic                        in_window, is_lo_read;
  logic [3:0]                  addr_off;
  logic [15:0]                 sel_val;
  logic                        unused_wdata;

  assign h_raw = {CH, BH, AH};
  assign l_raw = {CL, BL, AL};

  always_comb begin
    for (int p = 0; p < 3; p++) begin
      hs[p] = h_sync[p][SYNC_STAGES-1];
      ls[p] = l_sync[p][SYNC_STAGES-1];
    end
  end

  assign rise    = hs & ~hs_prev;
  assign capture = rise & armed & {3{enable}};

  // Set terms are OR-ed after the W1C mask, so a coincident set always wins.
  assign status_clr = (bus_wr && bus_addr == ADDR_STATUS) ? bus_wdata[5:0] : 6'h00;
  assign status_nxt = (status & ~status_clr) | {capture, hs & ls};

  // Byte registers 0x02..0x0D: offset[3:2] = phase, [1] = PER/HIGH, [0] = hi byte.
  assign in_window    = bus_addr inside {[ADDR_FIRST:ADDR_LAST]};
  assign addr_off     = bus_addr[3:0] - 4'd2;
  assign is_lo_read   = bus_rd && in_window && !addr_off[0];
  assign unused_wdata = ^bus_wdata[7:6];

  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    sel_val   = 16'h0000;
    bus_rdata = 8'h00;
    for (int p = 0; p < 3; p++) begin
      if (addr_off[3:2] == 2'(p)) sel_val = addr_off[1] ? per_reg[p] : high_reg[p];
    end
    if (bus_addr == ADDR_CTRL)        bus_rdata = {7'b0, enable};
    else if (bus_addr == ADDR_STATUS) bus_rdata = {2'b0, status};
    else if (in_window)               bus_rdata = addr_off[0] ? shadow : sel_val[7:0];
  end

  always_ff @(posedge clk_pwm) begin
    // NOTE: state uses non-blocking assignments only, and the synchronous reset
    // clears the capture/counter arrays too so no stale measurement survives it.
    if (!rst_n) begin
      h_sync     <= '0;
      l_sync     <= '0;
      hs_prev    <= '0;
      armed      <= '0;
      period_cnt <= '0;
      high_cnt   <= '0;
      per_reg    <= '0;
      high_reg   <= '0;
      enable     <= 1'b0;
      status     <= '0;
      shadow     <= '0;
      out_en     <= 1'b0;
      fault      <= 1'b0;
    end else begin
      for (int p = 0; p < 3; p++) begin
        h_sync[p] <= {h_sync[p][SYNC_STAGES-2:0], h_raw[p]};
        l_sync[p] <= {l_sync[p][SYNC_STAGES-2:0], l_raw[p]};

        if (!enable) begin
          period_cnt[p] <= '0;
          high_cnt[p]   <= '0;
          armed[p]      <= 1'b0;
        end else if (rise[p]) begin
          period_cnt[p] <= 16'd1;
          high_cnt[p]   <= 16'd1;
          armed[p]      <= 1'b1;
        end else begin
          if (period_cnt[p] != CNT_MAX)        period_cnt[p] <= period_cnt[p] + 16'd1;
          if (hs[p] && high_cnt[p] != CNT_MAX) high_cnt[p]   <= high_cnt[p] + 16'd1;
        end

        if (capture[p]) begin
          per_reg[p]  <= period_cnt[p];
          high_reg[p] <= high_cnt[p];
        end
      end

      hs_prev <= hs;
      status  <= status_nxt;
      fault   <= |status_nxt[2:0];
      out_en  <= bus_rd;
      if (bus_wr && bus_addr == ADDR_CTRL) enable <= bus_wdata[0];
      if (is_lo_read) shadow <= sel_val[15:8];
    end
  end

endmodule

// File: tb/tb_spwm_capture.sv
// Self-checking bench for spwm_capture: register-map vector table, directed
// corner-case sequences, then random gate/bus traffic against an event model.
module tb_spwm_capture;

  localparam int S = 2;

  logic       clk_pwm = 1'b0;
  logic       rst_n = 1'b0;
  logic       bus_wr = 1'b0, bus_rd = 1'b0;
  logic [5:0] bus_addr = 6'h00;
  logic [7:0] bus_wdata = 8'h00;
  logic [7:0] bus_rdata;
  logic       out_en, fault;
  logic       AH = 1'b0, AL = 1'b1, BH = 1'b0, BL = 1'b1, CH = 1'b0, CL = 1'b1;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  spwm_capture #(.SYNC_STAGES(S)) dut (
    .clk_pwm  (clk_pwm),
    .rst_n    (rst_n),
    .bus_wr   (bus_wr),
    .bus_rd   (bus_rd),
    .bus_addr (bus_addr),
    .bus_wdata(bus_wdata),
    .bus_rdata(bus_rdata),
    .out_en   (out_en),
    .AH       (AH),
    .AL       (AL),
    .BH       (BH),
    .BL       (BL),
    .CH       (CH),
    .CL       (CL),
    .fault    (fault)
  );

  always #5 clk_pwm = ~clk_pwm;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model (event/timestamp based) ----------------
  bit [2:0]  mq_h [$];
  bit [2:0]  mq_l [$];
  bit        m_en, m_out_en, m_fault;
  bit [5:0]  m_status;
  bit [15:0] m_per [3];
  bit [15:0] m_high [3];
  bit [7:0]  m_shadow;
  bit [2:0]  m_armed, m_prev;
  int        m_last [3];
  int        m_highs [3];
  int        m_n;

  function automatic bit [15:0] sat16(input int v);
    return (v > 65535) ? 16'hFFFF : 16'(v);
  endfunction

  function automatic bit [15:0] m_reg16(input logic [5:0] a);
    int idx;
    idx = (int'(a) - 2) / 2;
    return (idx % 2 == 1) ? m_per[idx / 2] : m_high[idx / 2];
  endfunction

  function automatic logic [7:0] m_rdata(input logic [5:0] a);
    bit [15:0] v;
    if (a == 6'h00) return {7'b0, m_en};
    if (a == 6'h01) return {2'b0, m_status};
    if (a >= 6'h02 && a <= 6'h0D) begin
      v = m_reg16(a);
      return (a[0] == 1'b0) ? v[7:0] : m_shadow;
    end
    return 8'h00;
  endfunction

  always @(posedge clk_pwm) begin : model
    bit [2:0] hs, ls, rise;
    bit [5:0] set_b, clr;
    if (!rst_n) begin
      mq_h.delete();
      mq_l.delete();
      for (int k = 0; k < S; k++) begin
        mq_h.push_back(3'b000);
        mq_l.push_back(3'b000);
      end
      m_en = 0; m_out_en = 0; m_fault = 0; m_status = '0; m_shadow = '0;
      m_armed = '0; m_prev = '0; m_n = 0;
      for (int p = 0; p < 3; p++) begin
        m_per[p] = '0; m_high[p] = '0; m_last[p] = 0; m_highs[p] = 0;
      end
    end else begin
      hs = mq_h.pop_front();
      ls = mq_l.pop_front();
      mq_h.push_back({CH, BH, AH});
      mq_l.push_back({CL, BL, AL});
      if (bus_rd && bus_addr >= 6'h02 && bus_addr <= 6'h0D && bus_addr[0] == 1'b0)
        m_shadow = m_reg16(bus_addr) >> 8;
      rise  = hs & ~m_prev;
      set_b = '0;
      for (int p = 0; p < 3; p++) begin
        if (hs[p] && ls[p]) set_b[p] = 1'b1;
        if (m_en && rise[p] && m_armed[p]) begin
          m_per[p]     = sat16(m_n - m_last[p]);
          m_high[p]    = sat16(m_highs[p]);
          set_b[3 + p] = 1'b1;
        end
        if (rise[p]) begin
          m_last[p]  = m_n;
          m_highs[p] = 1;
        end else if (hs[p]) begin
          m_highs[p] = m_highs[p] + 1;
        end
        m_armed[p] = m_en ? (m_armed[p] | rise[p]) : 1'b0;
      end
      m_prev   = hs;
      clr      = (bus_wr && bus_addr == 6'h01) ? bus_wdata[5:0] : 6'h00;
      m_status = (m_status & ~clr) | set_b;
      m_fault  = |m_status[2:0];
      m_out_en = bus_rd;
      if (bus_wr && bus_addr == 6'h00) m_en = bus_wdata[0];
      m_n = m_n + 1;
    end
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(negedge clk_pwm);
    cyc++;
  endtask

  task automatic bus_write(input logic [5:0] a, input logic [7:0] d);
    bus_addr  = a;
    bus_wdata = d;
    bus_wr    = 1'b1;
    step();
    bus_wr    = 1'b0;
  endtask

  task automatic bus_read(input logic [5:0] a, input logic [7:0] exp, input string name);
    bus_addr = a;
    bus_rd   = 1'b1;
    #1;
    check(name, bus_rdata, exp);
    step();
    bus_rd = 1'b0;
    check({name, "_out_en_hi"}, out_en, 1'b1);
    step();
    check({name, "_out_en_lo"}, out_en, 1'b0);
  endtask

  task automatic set_a(input logic h, input logic l);
    AH = h;
    AL = l;
  endtask

  typedef struct {
    bit         wr;
    logic [5:0] addr;
    logic [7:0] data;  // write data or expected read data
    string      name;
  } vec_t;

  vec_t vecs [14];
  int   r, r1;
  bit [2:0] hr, lr;

  initial begin
    vecs[0]  = '{1'b0, 6'h00, 8'h00, "ctrl_reset"};
    vecs[1]  = '{1'b0, 6'h01, 8'h00, "status_reset"};
    vecs[2]  = '{1'b0, 6'h04, 8'h00, "a_per_reset"};
    vecs[3]  = '{1'b1, 6'h00, 8'hFF, "wr_ctrl"};
    vecs[4]  = '{1'b0, 6'h00, 8'h01, "ctrl_enable_only_bit0"};
    vecs[5]  = '{1'b1, 6'h20, 8'hFF, "wr_unmapped"};
    vecs[6]  = '{1'b0, 6'h20, 8'h00, "unmapped_reads_zero"};
    vecs[7]  = '{1'b0, 6'h0E, 8'h00, "addr_0e_reads_zero"};
    vecs[8]  = '{1'b1, 6'h01, 8'hFF, "w1c_empty"};
    vecs[9]  = '{1'b0, 6'h01, 8'h00, "status_still_zero"};
    vecs[10] = '{1'b1, 6'h02, 8'hAA, "wr_a_high"};
    vecs[11] = '{1'b0, 6'h02, 8'h00, "a_high_read_only"};
    vecs[12] = '{1'b1, 6'h00, 8'h00, "wr_ctrl_off"};
    vecs[13] = '{1'b0, 6'h00, 8'h00, "ctrl_disabled"};

    repeat (3) step();
    rst_n = 1'b1;
    step();
    check("reset_fault", fault, 1'b0);
    check("reset_out_en", out_en, 1'b0);

    for (int i = 0; i < 14; i++) begin
      if (vecs[i].wr) bus_write(vecs[i].addr, vecs[i].data);
      else            bus_read(vecs[i].addr, vecs[i].data, vecs[i].name);
    end

    // 100-cycle period, 30 high, complementary low side
    bus_write(6'h00, 8'h01);
    for (int k = 0; k < 3; k++) begin
      set_a(1'b1, 1'b0);
      repeat (30) step();
      set_a(1'b0, 1'b1);
      repeat (70) step();
    end
    bus_read(6'h04, 8'h64, "a_per_lo_100");
    bus_read(6'h05, 8'h00, "a_per_hi_100");
    bus_read(6'h02, 8'h1E, "a_high_lo_30");
    bus_read(6'h03, 8'h00, "a_high_hi_30");
    bus_read(6'h01, 8'h08, "status_new_a");
    check("no_fault_square", fault, 1'b0);
    bus_write(6'h01, 8'h08);
    bus_read(6'h01, 8'h00, "status_new_a_cleared");

    // single-cycle overlap while disabled: fault exactly S+1 edges later
    bus_write(6'h00, 8'h00);
    set_a(1'b1, 1'b1);
    step();
    set_a(1'b0, 1'b1);
    repeat (S - 1) step();
    check("fault_not_yet", fault, 1'b0);
    step();
    check("fault_set", fault, 1'b1);
    bus_read(6'h01, 8'h01, "status_shoot_a");
    bus_write(6'h01, 8'h01);
    check("fault_cleared", fault, 1'b0);
    bus_read(6'h01, 8'h00, "status_shoot_cleared");

    // long low time saturates the period
    bus_write(6'h00, 8'h01);
    set_a(1'b1, 1'b0);
    repeat (10) step();
    set_a(1'b0, 1'b1);
    repeat (70000) step();
    set_a(1'b1, 1'b0);
    r1 = cyc;
    repeat (S + 3) step();
    bus_read(6'h02, 8'h0A, "a_high_lo_10");
    bus_read(6'h03, 8'h00, "a_high_hi_10");
    bus_read(6'h04, 8'hFF, "a_per_lo_sat");
    bus_read(6'h05, 8'hFF, "a_per_hi_sat");

    // shadow keeps the old hi byte across a capture between lo and hi reads
    bus_read(6'h04, 8'hFF, "a_per_lo_old");
    set_a(1'b0, 1'b1);
    while (cyc < r1 + 300) step();
    set_a(1'b1, 1'b0);
    repeat (S + 3) step();
    bus_read(6'h05, 8'hFF, "shadow_holds_old_hi");
    bus_read(6'h04, 8'h2C, "a_per_lo_300");
    bus_read(6'h05, 8'h01, "a_per_hi_300");

    // W1C of bit3 on the exact capture edge: set wins
    bus_read(6'h01, 8'h08, "status_before_race");
    set_a(1'b0, 1'b1);
    repeat (10) step();
    set_a(1'b1, 1'b0);
    repeat (S) step();
    bus_addr  = 6'h01;
    bus_wdata = 8'h08;
    bus_wr    = 1'b1;
    step();
    bus_wr    = 1'b0;
    bus_read(6'h01, 8'h08, "set_wins_over_w1c");
    bus_write(6'h01, 8'h08);
    bus_read(6'h01, 8'h00, "w1c_alone_clears");

    // reset mid-period discards the measurement and re-arms from scratch
    set_a(1'b0, 1'b1);
    repeat (40) step();
    set_a(1'b1, 1'b0);
    repeat (20) step();
    set_a(1'b0, 1'b1);
    repeat (30) step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("post_reset_fault", fault, 1'b0);
    for (int a = 0; a < 14; a++) bus_read(6'(a), 8'h00, $sformatf("post_reset_reg_%0h", a));
    bus_write(6'h00, 8'h01);
    set_a(1'b1, 1'b0);
    r = cyc;
    repeat (30) step();
    set_a(1'b0, 1'b1);
    repeat (20) step();
    bus_read(6'h04, 8'h00, "first_edge_only_arms");
    bus_read(6'h01, 8'h00, "first_edge_no_flag");
    while (cyc < r + 100) step();
    set_a(1'b1, 1'b0);
    repeat (S + 3) step();
    bus_read(6'h04, 8'h64, "second_edge_captures_lo");
    bus_read(6'h05, 8'h00, "second_edge_captures_hi");
    bus_read(6'h01, 8'h08, "second_edge_flag");

    // random three-phase traffic against the model
    hr = {CH, BH, AH};
    lr = {CL, BL, AL};
    for (int i = 0; i < 4000; i++) begin
      for (int p = 0; p < 3; p++) begin
        if ($urandom_range(0, 19) == 0) hr[p] = ~hr[p];
        lr[p] = ~hr[p];
        if ($urandom_range(0, 149) == 0) lr[p] = hr[p];
      end
      {CH, BH, AH} = hr;
      {CL, BL, AL} = lr;
      bus_wr = 1'b0;
      bus_rd = 1'b0;
      r = $urandom_range(0, 9);
      if (r == 0) begin
        bus_wr    = 1'b1;
        bus_addr  = 6'h00;
        bus_wdata = ($urandom_range(0, 7) != 0) ? 8'h01 : 8'h00;
      end else if (r == 1) begin
        bus_wr    = 1'b1;
        bus_addr  = 6'h01;
        bus_wdata = 8'($urandom);
      end else if (r <= 5) begin
        bus_rd   = 1'b1;
        bus_addr = 6'($urandom_range(0, 15));
      end
      #1;
      if (bus_rd) check("rnd_rdata", bus_rdata, m_rdata(bus_addr));
      check("rnd_out_en", out_en, m_out_en);
      check("rnd_fault", fault, m_fault);
      step();
    end
    bus_wr = 1'b0;
    bus_rd = 1'b0;
    step();
    for (int a = 0; a < 16; a++) begin
      bus_addr = 6'(a);
      #1;
      check("final_rdata", bus_rdata, m_rdata(bus_addr));
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
